// File: rtl/led_scan_sequencer.sv
// LED scan sequencer: two debounced push-buttons drive a run/pause/step FSM
// that walks a 3-bit scan index up, down or ping-pong and decodes it to active-low LEDs.
module led_scan_sequencer #(
    parameter int DIV = 12000000,
    parameter int DEB = 240000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       key_run,
    input  logic       key_step,
    output logic [2:0] sel,
    output logic [7:0] led,
    output logic       running,
    output logic       step_pulse
);

    localparam int PW = $clog2(DIV);
    localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB - 1);
    localparam logic [DW-1:0] DEB_ONE    = DW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Key index 0 is key_run, index 1 is key_step.
    logic [1:0]    w_keyRaw;
    logic [1:0]    r_sync0;
    logic [1:0]    r_sync1;
    logic [1:0]    r_deb;
    logic [1:0]    r_press;
    logic [DW-1:0] r_debCnt [2];

    state_t        r_state;
    state_t        w_nextState;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_prescNext;
    logic          w_advance;
    logic          w_runPress;
    logic          w_stepPress;

    logic [2:0]    r_sel;
    logic [2:0]    w_selNext;
    logic          r_dirUp;
    logic          w_dirNext;
    logic          r_stepPulse;
    logic          w_pulseNext;
    logic          r_running;

    assign w_keyRaw = {key_step, key_run};

    // A level change is accepted only after DEB consecutive disagreeing cycles;
    // the press pulse fires in the cycle the debounced level first reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= 2'b11;
            r_sync1 <= 2'b11;
            r_deb   <= 2'b11;
            r_press <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                r_debCnt[k] <= '0;
            end
        end else begin
            r_sync0 <= w_keyRaw;
            r_sync1 <= r_sync0;
            for (int k = 0; k < 2; k++) begin
                r_press[k] <= 1'b0;
                if (r_sync1[k] == r_deb[k]) begin
                    r_debCnt[k] <= '0;
                end else if (r_debCnt[k] == DEB_LAST) begin
                    r_debCnt[k] <= '0;
                    r_deb[k]    <= r_sync1[k];
                    r_press[k]  <= ~r_sync1[k];
                end else begin
                    r_debCnt[k] <= r_debCnt[k] + DEB_ONE;
                end
            end
        end
    end

    assign w_runPress  = r_press[0];
    assign w_stepPress = r_press[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A run press always wins: it suppresses both the prescaler tick and any step press.
    always_comb begin
        w_nextState = r_state;
        w_prescNext = r_presc;
        w_advance   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_runPress) begin
                    w_nextState = RUN;
                    w_prescNext = '0;
                end
            end
            RUN: begin
                if (w_runPress) begin
                    w_nextState = PAUSE;
                end else if (r_presc == PRESC_LAST) begin
                    w_prescNext = '0;
                    w_advance   = 1'b1;
                end else begin
                    w_prescNext = r_presc + PRESC_ONE;
                end
            end
            PAUSE: begin
                if (w_runPress) begin
                    w_nextState = RUN;
                end else if (w_stepPress) begin
                    w_prescNext = '0;
                    w_advance   = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_prescNext = '0;
            end
        endcase
    end

    always_comb begin
        w_selNext   = r_sel;
        w_dirNext   = r_dirUp;
        w_pulseNext = 1'b0;
        if (w_advance) begin
            unique case (mode)
                2'b00: begin
                    w_selNext   = r_sel + 3'd1;
                    w_pulseNext = 1'b1;
                end
                2'b01: begin
                    w_selNext   = r_sel - 3'd1;
                    w_pulseNext = 1'b1;
                end
                2'b10: begin
                    w_pulseNext = 1'b1;
                    if (r_dirUp) begin
                        if (r_sel == 3'd7) begin
                            w_selNext = 3'd6;
                            w_dirNext = 1'b0;
                        end else begin
                            w_selNext = r_sel + 3'd1;
                        end
                    end else begin
                        if (r_sel == 3'd0) begin
                            w_selNext = 3'd1;
                            w_dirNext = 1'b1;
                        end else begin
                            w_selNext = r_sel - 3'd1;
                        end
                    end
                end
                default: begin
                    w_selNext = r_sel;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc     <= '0;
            r_sel       <= 3'd0;
            r_dirUp     <= 1'b1;
            r_stepPulse <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_presc     <= w_prescNext;
            r_sel       <= w_selNext;
            r_dirUp     <= w_dirNext;
            r_stepPulse <= w_pulseNext;
            r_running   <= (w_nextState == RUN);
        end
    end

    assign sel        = r_sel;
    assign led        = ~(8'h80 >> r_sel);
    assign running    = r_running;
    assign step_pulse = r_stepPulse;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Bench for led_scan_sequencer: behavioural model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_led_scan_sequencer;

    localparam int DIV = 4;
    localparam int DEB = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       key_run = 1'b1;
    logic       key_step = 1'b1;
    logic [2:0] sel;
    logic [7:0] led;
    logic       running;
    logic       step_pulse;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    led_scan_sequencer #(.DIV(DIV), .DEB(DEB)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .key_run    (key_run),
        .key_step   (key_step),
        .sel        (sel),
        .led        (led),
        .running    (running),
        .step_pulse (step_pulse)
    );

    function automatic int ledFor(input int s);
        case (s)
            0: return 'h7F;
            1: return 'hBF;
            2: return 'hDF;
            3: return 'hEF;
            4: return 'hF7;
            5: return 'hFB;
            6: return 'hFD;
            default: return 'hFE;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model of the required behaviour, kept in plain integers.
    bit modelValid = 1'b0;
    int mS1 [2];
    int mS2 [2];
    int mDeb [2];
    int mLen [2];
    int mPress [2];
    int raw [2];
    bit mActive, mRunning, mDirUp, expPulse, runP, stepP, adv;
    int mPresc, expSel;

    always @(posedge clk) begin
        if (rst) begin
            modelValid = 1'b1;
            for (int k = 0; k < 2; k++) begin
                mS1[k] = 1; mS2[k] = 1; mDeb[k] = 1; mLen[k] = 0; mPress[k] = 0;
            end
            mActive = 0; mRunning = 0; mDirUp = 1; mPresc = 0; expSel = 0; expPulse = 0;
        end else begin
            runP = (mPress[0] != 0);
            stepP = (mPress[1] != 0);
            raw[0] = int'(key_run);
            raw[1] = int'(key_step);
            for (int k = 0; k < 2; k++) begin
                mPress[k] = 0;
                if (mS2[k] != mDeb[k]) begin
                    mLen[k]++;
                    if (mLen[k] >= DEB) begin
                        mDeb[k] = mS2[k];
                        mLen[k] = 0;
                        mPress[k] = (mDeb[k] == 0) ? 1 : 0;
                    end
                end else begin
                    mLen[k] = 0;
                end
                mS2[k] = mS1[k];
                mS1[k] = raw[k];
            end
            adv = 0;
            if (!mActive) begin
                if (runP) begin mActive = 1; mRunning = 1; mPresc = 0; end
            end else if (mRunning) begin
                if (runP) mRunning = 0;
                else if (mPresc == DIV - 1) begin mPresc = 0; adv = 1; end
                else mPresc++;
            end else begin
                if (runP) mRunning = 1;
                else if (stepP) begin adv = 1; mPresc = 0; end
            end
            expPulse = 0;
            if (adv) begin
                case (mode)
                    2'd0: begin expSel = (expSel + 1) % 8; expPulse = 1; end
                    2'd1: begin expSel = (expSel + 7) % 8; expPulse = 1; end
                    2'd2: begin
                        expPulse = 1;
                        if (mDirUp && expSel == 7) begin expSel = 6; mDirUp = 0; end
                        else if (!mDirUp && expSel == 0) begin expSel = 1; mDirUp = 1; end
                        else expSel = mDirUp ? expSel + 1 : expSel - 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    int  cyc = 0;
    int  pulseCount = 0;
    int  pulseCyc = 0;
    int  riseCyc = 0;
    int  selAtRise = -1;
    int  pulseAtRise = -1;
    bit  prevRunning = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (modelValid) begin
            checkOutput("model.sel", sel, expSel);
            checkOutput("model.led", led, ledFor(expSel));
            checkOutput("model.running", running, mRunning);
            checkOutput("model.step_pulse", step_pulse, expPulse);
        end
        if (step_pulse === 1'b1) begin
            pulseCount++;
            pulseCyc = cyc;
        end
        if (running === 1'b1 && !prevRunning) begin
            riseCyc = cyc;
            selAtRise = int'(sel);
            pulseAtRise = int'(step_pulse);
        end
        prevRunning = (running === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input bit pressRun, input bit pressStep);
        key_run = pressRun ? 1'b0 : 1'b1;
        key_step = pressStep ? 1'b0 : 1'b1;
        tick(4);
        key_run = 1'b1;
        key_step = 1'b1;
        tick(1);
    endtask

    task automatic waitPulse(input int budget, output int waited);
        waited = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            waited++;
            if (step_pulse === 1'b1) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL waitPulse: no step_pulse within %0d cycles, expected one", budget);
    endtask

    int upSel [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    int upLed [8] = '{'hBF, 'hDF, 'hEF, 'hF7, 'hFB, 'hFD, 'hFE, 'h7F};
    int ppSel [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int dnSel [3] = '{0, 7, 6};

    initial begin
        int w, pc;
        bit found;
        tick(3);
        checkOutput("reset.sel", sel, 0);
        checkOutput("reset.led", led, 'h7F);
        checkOutput("reset.running", running, 0);
        checkOutput("reset.step_pulse", step_pulse, 0);
        rst = 1'b0;
        tick(3);
        checkOutput("idle.running", running, 0);

        // Up count: one advance every DIV cycles.
        applyStimulus(1'b0, 1'b1);
        tick(4);
        checkOutput("idle.step_ignored", sel, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("up.running", running, 1);
        for (int i = 0; i < 8; i++) begin
            waitPulse(20, w);
            checkOutput($sformatf("up.sel[%0d]", i), sel, upSel[i]);
            checkOutput($sformatf("up.led[%0d]", i), led, upLed[i]);
            checkOutput($sformatf("up.gap[%0d]", i), w, 4);
        end

        // Ping-pong from 0 upward.
        mode = 2'b10;
        for (int i = 0; i < 15; i++) begin
            waitPulse(20, w);
            checkOutput($sformatf("pp.sel[%0d]", i), sel, ppSel[i]);
        end

        // Down count, then pause at 5.
        mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            waitPulse(20, w);
            checkOutput($sformatf("dn.sel[%0d]", i), sel, dnSel[i]);
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("pause.running", running, 0);
        checkOutput("pause.sel", sel, 5);
        tick(4);
        pc = pulseCount;
        tick(20);
        checkOutput("pause.frozen_sel", sel, 5);
        checkOutput("pause.no_pulse", pulseCount - pc, 0);

        applyStimulus(1'b0, 1'b1);
        tick(4);
        checkOutput("step1.sel", sel, 4);
        checkOutput("step1.pulses", pulseCount - pc, 1);
        applyStimulus(1'b0, 1'b1);
        tick(4);
        checkOutput("step2.sel", sel, 3);
        checkOutput("step2.pulses", pulseCount - pc, 2);

        // Both keys together: run wins, step discarded.
        applyStimulus(1'b1, 1'b1);
        tick(4);
        checkOutput("both.running", running, 1);
        checkOutput("both.sel_at_resume", selAtRise, 3);
        checkOutput("both.pulse_at_resume", pulseAtRise, 0);

        // Pause with prescaler at 2, then resume from the held count.
        waitPulse(20, w);
        tick(2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("hold2.running", running, 0);
        tick(4);
        applyStimulus(1'b1, 1'b0);
        tick(4);
        checkOutput("hold2.resume_gap", pulseCyc - riseCyc, 2);

        // One-cycle glitch on key_run is rejected.
        key_run = 1'b0;
        tick(1);
        key_run = 1'b1;
        tick(10);
        checkOutput("glitch.running", running, 1);

        // Hold mode: prescaler runs, no advances shown.
        waitPulse(20, w);
        tick(1);
        pc = pulseCount;
        mode = 2'b11;
        tick(12);
        checkOutput("hold.no_pulse", pulseCount - pc, 0);
        mode = 2'b00;

        // Reset in RUN at sel=5 with prescaler at 2.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            waitPulse(20, w);
            if (sel == 3'd5) found = 1'b1;
        end
        checkOutput("rst.found_sel5", found, 1);
        tick(2);
        rst = 1'b1;
        tick(1);
        checkOutput("rst.sel", sel, 0);
        checkOutput("rst.led", led, 'h7F);
        checkOutput("rst.running", running, 0);
        checkOutput("rst.step_pulse", step_pulse, 0);
        rst = 1'b0;
        tick(10);
        checkOutput("rst.stays_idle", running, 0);
        checkOutput("rst.sel_idle", sel, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/led_scan_sequencer.md
LED_SCAN_SEQUENCER -- requirements
Module: led_scan_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 12000000, clock cycles per automatic step (legal range DIV >= 2).
REQ-002 SHALL have parameter DEB, default 240000, consecutive stable cycles required to accept a key level change (legal range DEB >= 1).
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port mode, input, 2: 00 up, 01 down, 10 ping-pong, 11 hold.
REQ-006 SHALL have port key_run, input, 1, raw asynchronous push-button, active-low; press toggles run/pause.
REQ-007 SHALL have port key_step, input, 1, raw asynchronous push-button, active-low; press single-steps while paused.
REQ-008 SHALL have port sel, output, 3, current scan index.
REQ-009 SHALL have port led, output, 8, active-low one-hot decode of sel.
REQ-010 SHALL have port running, output, 1, high while in RUN.
REQ-011 SHALL have port step_pulse, output, 1, one-cycle pulse in the cycle sel is updated by an advance.

Function
REQ-012 SHALL pass each key through a two-flop synchronizer before any other use.
REQ-013 SHALL keep a debounced level per key (reset value 1) that takes the synchronized value only after it has differed from the debounced level for DEB consecutive cycles; any agreeing cycle restarts the count.
REQ-014 SHALL generate a one-cycle press pulse on each debounced 1->0 transition; a release generates no pulse.
REQ-015 SHALL implement FSM states IDLE (reset), RUN, PAUSE.
REQ-016 In IDLE: run press -> RUN with prescaler = 0; step press ignored.
REQ-017 In RUN: prescaler counts 0..DIV-1; the cycle it equals DIV-1 it wraps to 0 and an advance occurs; run press -> PAUSE; step press ignored.
REQ-018 In PAUSE: prescaler holds its value; run press -> RUN, resuming from the held count; step press performs one advance and clears prescaler to 0.
REQ-019 When run press and step press coincide, run press SHALL take effect and step press SHALL be discarded.
REQ-020 Advance, mode 00: sel+1 modulo 8 (7 -> 0).
REQ-021 Advance, mode 01: sel-1 modulo 8 (0 -> 7).
REQ-022 Advance, mode 10: internal dir (reset = up) applied; at sel=7 moving up: sel=6, dir=down; at sel=0 moving down: sel=1, dir=up; sequence 0..7,6..0,1...
REQ-023 Advance, mode 11: sel unchanged, step_pulse not asserted; prescaler continues to run.
REQ-024 dir SHALL hold its value outside mode 10; mode changes take effect at the next advance only.
REQ-025 step_pulse SHALL assert in exactly the cycle sel takes its new value (modes 00/01/10).
REQ-026 led SHALL be a combinational function of registered sel: led = ~(8'h80 >> sel); sel 0 -> 8'h7F, 3 -> 8'hEF, 7 -> 8'hFE.
REQ-027 running SHALL equal (state == RUN), registered.

Reset
REQ-028 With rst high at a clock edge: state IDLE, sel 0, led 8'h7F, dir up, prescaler 0, debounced levels 1, debounce counts 0, synchronizers 1, running 0, step_pulse 0.
REQ-029 Reset SHALL override all other activity, including mid-step and mid-debounce; no press pulse is produced by reset release.

Verification (DIV=4, DEB=2)
REQ-030 Reset -> sel=0, led=8'h7F, running=0, step_pulse=0.
REQ-031 Mode 00, press key_run -> running=1; sel 0,1,...,7,0 every 4 cycles; led 7F,BF,DF,EF,F7,FB,FD,FE,7F; step_pulse each update.
REQ-032 Mode 10 running -> sel 0..7,6,5,...,0,1; no repeated index at turnaround.
REQ-033 Running mode 01 at sel=5, press key_run -> running=0, sel frozen for 20 cycles; two key_step presses -> sel 4 then 3, one step_pulse each; key_run press -> resumes from held prescaler count.
REQ-034 key_run low for 1 synchronized cycle only -> no state change; simultaneous run and step presses in PAUSE -> RUN, sel unchanged.
REQ-035 rst asserted in RUN at sel=5, prescaler=2 -> next cycle sel=0, led=8'h7F, IDLE, running=0.
